// File: rtl/ram_read_streamer.sv
// ram_read_streamer: command-driven RAM read engine that returns
// Length words from a 1-cycle-latency RAM as a valid/ready/last stream.
module ram_read_streamer #(
    parameter int AddressWidth       = 32,
    parameter int DataWidth          = 32,
    parameter int InnerIFLengthWidth = 16,
    parameter int RamAddrWidth       = 10,
    parameter logic [RamAddrWidth-1:0] SpareBase = 10'h300,
    parameter int FifoDepth          = 4
) (
    input  logic                          iClock,
    input  logic                          iReset,
    input  logic [5:0]                    iSrcOpcode,
    input  logic [4:0]                    iSrcTargetID,
    input  logic [4:0]                    iSrcSourceID,
    input  logic [AddressWidth-1:0]       iSrcAddress,
    input  logic [InnerIFLengthWidth-1:0] iSrcLength,
    input  logic                          iSrcCmdValid,
    output logic                          oSrcCmdReady,
    output logic [DataWidth-1:0]          oSrcReadData,
    output logic                          oSrcReadValid,
    output logic                          oSrcReadLast,
    input  logic                          iSrcReadReady,
    output logic [RamAddrWidth-1:0]       oRamAddr,
    output logic                          oRamReadEnable,
    input  logic [DataWidth-1:0]          iRamReadData
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    localparam int ByteShift = $clog2(DataWidth / 8);
    localparam logic [2:0] Depth = 3'(FifoDepth);
    localparam logic [5:0] OpPage  = 6'b000001;
    localparam logic [5:0] OpSpare = 6'b000010;

    state_t r_state;
    state_t w_next;

    logic                          w_accept;
    logic                          w_is_page;
    logic                          w_is_spare;
    logic                          w_start;
    logic [AddressWidth-1:0]       w_word_addr;
    logic [RamAddrWidth-1:0]       w_start_addr;

    logic [RamAddrWidth-1:0]       r_addr;
    logic [InnerIFLengthWidth-1:0] r_remaining;
    logic                          w_final_issue;
    logic                          r_inflight;
    logic                          r_inflight_last;
    logic [9:0]                    r_ids;

    logic [DataWidth-1:0]          r_mem [4];
    logic [3:0]                    r_last_bits;
    logic [1:0]                    r_wr_ptr;
    logic [1:0]                    r_rd_ptr;
    logic [2:0]                    r_count;
    logic [2:0]                    w_occ;

    logic                          w_issue;
    logic                          w_push;
    logic                          w_pop;
    logic                          w_valid;
    logic                          w_head_last;
    logic                          w_unused;

    // Command decode and start-address computation at accept.
    assign w_accept     = (r_state == S_IDLE) && iSrcCmdValid;
    assign w_is_page    = (iSrcOpcode == OpPage);
    assign w_is_spare   = (iSrcOpcode == OpSpare);
    assign w_start      = w_accept && (w_is_page || w_is_spare)
                          && (iSrcLength != '0);
    assign w_word_addr  = iSrcAddress >> ByteShift;
    assign w_start_addr = w_word_addr[RamAddrWidth-1:0]
                          + (w_is_spare ? SpareBase : '0);

    // One read in flight at most; credits cover FIFO plus in-flight word.
    assign w_occ         = r_count + {2'b00, r_inflight};
    assign w_issue       = (r_state == S_ISSUE) && (w_occ < Depth);
    assign w_final_issue = w_issue
                           && (r_remaining == InnerIFLengthWidth'(1));

    assign w_push      = r_inflight;
    assign w_valid     = (r_count != 3'd0);
    assign w_head_last = r_last_bits[r_rd_ptr];
    assign w_pop       = w_valid && iSrcReadReady;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (w_final_issue) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_pop && w_head_last) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_state         <= S_IDLE;
            r_addr          <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_ids           <= '0;
        end else begin
            r_state         <= w_next;
            r_inflight      <= w_issue;
            r_inflight_last <= w_final_issue;
            if (w_accept) r_ids <= {iSrcTargetID, iSrcSourceID};
            if (w_start) begin
                r_addr      <= w_start_addr;
                r_remaining <= iSrcLength;
            end else if (w_issue) begin
                r_addr      <= r_addr + RamAddrWidth'(1);
                r_remaining <= r_remaining - InnerIFLengthWidth'(1);
            end
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_wr_ptr    <= 2'd0;
            r_rd_ptr    <= 2'd0;
            r_count     <= 3'd0;
            r_last_bits <= 4'd0;
        end else begin
            if (w_push) begin
                r_last_bits[r_wr_ptr] <= r_inflight_last;
                r_wr_ptr              <= r_wr_ptr + 2'd1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
            r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
        end
    end

    // Payload storage needs no reset: outputs are gated by occupancy.
    always_ff @(posedge iClock) begin
        if (w_push) r_mem[r_wr_ptr] <= iRamReadData;
    end

    assign oSrcCmdReady   = (r_state == S_IDLE);
    assign oRamReadEnable = w_issue;
    assign oRamAddr       = r_addr;
    assign oSrcReadValid  = w_valid;
    assign oSrcReadData   = w_valid ? r_mem[r_rd_ptr] : '0;
    assign oSrcReadLast   = w_valid && w_head_last;

    assign w_unused = ^{r_ids, w_word_addr[AddressWidth-1:RamAddrWidth]};

endmodule

// File: tb/tb_ram_read_streamer.sv
// tb_ram_read_streamer: table vectors plus scoreboarded corner-case
// sequences against a behavioural RAM and stream model.
module tb_ram_read_streamer;

    logic        clk = 1'b0;
    logic        iReset = 1'b1;
    logic [5:0]  iSrcOpcode = '0;
    logic [4:0]  iSrcTargetID = '0;
    logic [4:0]  iSrcSourceID = '0;
    logic [31:0] iSrcAddress = '0;
    logic [15:0] iSrcLength = '0;
    logic        iSrcCmdValid = 1'b0;
    logic        oSrcCmdReady;
    logic [31:0] oSrcReadData;
    logic        oSrcReadValid;
    logic        oSrcReadLast;
    logic        iSrcReadReady = 1'b1;
    logic [9:0]  oRamAddr;
    logic        oRamReadEnable;
    logic [31:0] iRamReadData;

    ram_read_streamer dut (
        .iClock(clk),
        .iReset(iReset),
        .iSrcOpcode(iSrcOpcode),
        .iSrcTargetID(iSrcTargetID),
        .iSrcSourceID(iSrcSourceID),
        .iSrcAddress(iSrcAddress),
        .iSrcLength(iSrcLength),
        .iSrcCmdValid(iSrcCmdValid),
        .oSrcCmdReady(oSrcCmdReady),
        .oSrcReadData(oSrcReadData),
        .oSrcReadValid(oSrcReadValid),
        .oSrcReadLast(oSrcReadLast),
        .iSrcReadReady(iSrcReadReady),
        .oRamAddr(oRamAddr),
        .oRamReadEnable(oRamReadEnable),
        .iRamReadData(iRamReadData)
    );

    always #5 clk = ~clk;

    logic [31:0] ram_m [1024];
    logic [31:0] ram_q;
    always @(posedge clk) if (oRamReadEnable) ram_q <= ram_m[oRamAddr];
    assign iRamReadData = ram_q;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [15:0] len;
        int          exp_reads;
        logic [9:0]  exp_first;
    } vec_t;

    beat_t      beat_q[$];
    logic [9:0] addr_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int en_count = 0;
    int beat_count = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got unexpected event, expected none", nm);
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!iReset) begin
            if (oRamReadEnable) begin
                en_count++;
                if (addr_q.size() == 0) fail_now("ram_read_extra");
                else chk("ram_addr", oRamAddr, addr_q.pop_front());
            end
            if (!oSrcReadValid) chk("last_when_idle", oSrcReadLast, 0);
            if (oSrcReadValid && iSrcReadReady) begin
                beat_t e;
                beat_count++;
                if (beat_q.size() == 0) fail_now("beat_extra");
                else begin
                    e = beat_q.pop_front();
                    chk("beat_data", oSrcReadData, e.data);
                    chk("beat_last", oSrcReadLast, e.last);
                end
            end
        end
    end

    task automatic send_cmd(input logic [5:0] op, input logic [31:0] a,
                            input logic [15:0] len);
        int k;
        logic [9:0] start;
        logic [9:0] wa;
        k = 0;
        while (!oSrcCmdReady && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("cmd_ready_timeout", k < 400, 1);
        if ((op == 6'd1 || op == 6'd2) && len != 0) begin
            start = 10'((a >> 2) + ((op == 6'd2) ? 32'h300 : 32'h0));
            for (int i = 0; i < int'(len); i++) begin
                wa = start + 10'(i);
                addr_q.push_back(wa);
                beat_q.push_back('{ram_m[wa], (i == int'(len) - 1)});
            end
        end
        iSrcOpcode   = op;
        iSrcAddress  = a;
        iSrcLength   = len;
        iSrcTargetID = 5'h3;
        iSrcSourceID = 5'h5;
        iSrcCmdValid = 1'b1;
        @(posedge clk);
        #1;
        iSrcCmdValid = 1'b0;
        iSrcOpcode   = '0;
    endtask

    task automatic wait_done(input bit rnd);
        int k;
        k = 0;
        while (!oSrcCmdReady && k < 400) begin
            @(posedge clk);
            #1;
            if (rnd) iSrcReadReady = 1'($urandom_range(0, 1));
            k++;
        end
        chk("done_timeout", k < 400, 1);
        iSrcReadReady = 1'b1;
    endtask

    vec_t vecs [8];
    int en_base;
    int bt_base;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) ram_m[i] = 32'(i) * 32'h11111111;
        vecs[0] = '{6'd1, 32'h010, 16'd4, 4, 10'h004};
        vecs[1] = '{6'd2, 32'h3F8, 16'd3, 3, 10'h3FE};
        vecs[2] = '{6'd5, 32'h000, 16'd5, 0, 10'h000};
        vecs[3] = '{6'd1, 32'h040, 16'd0, 0, 10'h000};
        vecs[4] = '{6'd1, 32'h020, 16'd1, 1, 10'h008};
        vecs[5] = '{6'd2, 32'h000, 16'd2, 2, 10'h300};
        vecs[6] = '{6'd1, 32'hFFC, 16'd2, 2, 10'h3FF};
        vecs[7] = '{6'd1, 32'h1004, 16'd3, 3, 10'h001};

        repeat (3) @(posedge clk);
        #1;
        iReset = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", oSrcCmdReady, 1);
        chk("rst_valid", oSrcReadValid, 0);
        chk("rst_last", oSrcReadLast, 0);
        chk("rst_data", oSrcReadData, 0);
        chk("rst_ram_en", oRamReadEnable, 0);
        chk("rst_ram_addr", oRamAddr, 0);

        // Single page read: cycle-exact latency and throughput.
        send_cmd(6'd1, 32'h10, 16'd4);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            chk("t1_ram_en", oRamReadEnable, (c <= 4));
            chk("t1_valid", oSrcReadValid, (c >= 3 && c <= 6));
            chk("t1_last", oSrcReadLast, (c == 6));
            chk("t1_cmd_ready", oSrcCmdReady, (c == 7));
        end
        chk("t1_first_data", 32'h44444444, ram_m[4]);

        for (int v = 0; v < 8; v++) begin
            en_base = en_count;
            bt_base = beat_count;
            send_cmd(vecs[v].op, vecs[v].addr, vecs[v].len);
            @(negedge clk);
            chk("vec_ram_en", oRamReadEnable, (vecs[v].exp_reads > 0));
            if (vecs[v].exp_reads > 0) chk("vec_first_addr", oRamAddr, vecs[v].exp_first);
            else chk("vec_absorb_ready", oSrcCmdReady, 1);
            wait_done(0);
            chk("vec_reads", en_count - en_base, vecs[v].exp_reads);
            chk("vec_beats", beat_count - bt_base, vecs[v].exp_reads);
        end

        // Back-to-back absorption then one single-beat read.
        en_base = en_count;
        bt_base = beat_count;
        send_cmd(6'b000101, 32'h0, 16'd5);
        chk("abs_ready_1", oSrcCmdReady, 1);
        send_cmd(6'd1, 32'h0, 16'd0);
        chk("abs_ready_2", oSrcCmdReady, 1);
        send_cmd(6'd1, 32'h20, 16'd1);
        wait_done(0);
        chk("abs_reads", en_count - en_base, 1);
        chk("abs_beats", beat_count - bt_base, 1);

        // Backpressure: four credits, stable head, in-order delivery.
        en_base = en_count;
        bt_base = beat_count;
        iSrcReadReady = 1'b0;
        send_cmd(6'd1, 32'h40, 16'd8);
        begin
            int k;
            k = 0;
            while (!oSrcReadValid && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk("bp_valid_timeout", k < 20, 1);
        end
        for (int i = 0; i < 10; i++) begin
            chk("bp_head_data", oSrcReadData, ram_m[16]);
            chk("bp_head_valid", oSrcReadValid, 1);
            @(negedge clk);
        end
        chk("bp_reads_stalled", en_count - en_base, 4);
        iSrcReadReady = 1'b1;
        wait_done(0);
        chk("bp_reads", en_count - en_base, 8);
        chk("bp_beats", beat_count - bt_base, 8);
        chk("bp_beats_left", beat_q.size(), 0);

        // Reset pulse during beat 3 of an 8-beat read.
        bt_base = beat_count;
        send_cmd(6'd1, 32'h80, 16'd8);
        repeat (4) @(posedge clk);
        #1;
        iReset = 1'b1;
        @(posedge clk);
        #1;
        iReset = 1'b0;
        chk("rst_mid_beats", beat_count - bt_base, 2);
        addr_q.delete();
        beat_q.delete();
        @(negedge clk);
        chk("rst_mid_valid", oSrcReadValid, 0);
        chk("rst_mid_ready", oSrcCmdReady, 1);
        chk("rst_mid_ram_en", oRamReadEnable, 0);
        bt_base = beat_count;
        send_cmd(6'd1, 32'h30, 16'd2);
        wait_done(0);
        chk("rst_after_beats", beat_count - bt_base, 2);

        // Random ready with a 16-beat read.
        bt_base = beat_count;
        send_cmd(6'd1, 32'h100, 16'd16);
        wait_done(1);
        chk("rnd_beats", beat_count - bt_base, 16);
        chk("rnd_beats_left", beat_q.size(), 0);
        chk("rnd_addrs_left", addr_q.size(), 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
